period_meter: RTL

//   Measures the period (and optionally the high time) of a slow external or

---
 rtl/period_meter_if.sv | 22 ++
 rtl/period_meter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/period_meter_if.sv
// Result port of period_meter: measured period/high time with a valid/ready
// handshake, plus the timeout and overrun status flags.
interface period_meter_if #(
  parameter int unsigned CNT_W = 32
);
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             meas_ready;
  logic             timeout;
  logic             overrun;

  modport master (
    output period_out, high_out, meas_valid, timeout, overrun,
    input  meas_ready
  );

  modport slave (
    input  period_out, high_out, meas_valid, timeout, overrun,
    output meas_ready
  );
endinterface

// File: rtl/period_meter.sv
// Counts clk cycles between rising edges of an asynchronous input and reports
// them over a valid/ready port. High-time measurement is built when DUTY_MEAS_EN is defined.
module period_meter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 50000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           sig_in,
  period_meter_if.master res
);
  localparam int unsigned      MSB       = SYNC_STAGES - 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  if (TIMEOUT < 2) begin : g_bad_timeout_min
    $error("period_meter: TIMEOUT must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("period_meter: SYNC_STAGES must be >= 2");
  end
  if (CNT_W < 64 && 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout_width
    $error("period_meter: TIMEOUT must be below 2**CNT_W so counters cannot wrap");
  end

  typedef enum logic {ARM, MEASURE} state_t;

  state_t             state, state_next;
  logic [MSB:0]       sync_ff;
  logic               sig_d;
  logic               rise_p;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   period_q;
  logic               valid_q;
  logic               overrun_q;
  logic               timeout_q;
  logic               start;
  logic               capture;
  logic               expire;
  logic               load;
  logic               hs;

  // sig_d is the synchronized level delayed to line up with the registered rise pulse
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_ff <= '0;
      sig_d   <= 1'b0;
      rise_p  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[MSB-1:0], sig_in};
      sig_d   <= sync_ff[MSB];
      rise_p  <= sync_ff[MSB] & ~sig_d;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= ARM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    case (state)
      ARM: begin
        if (rise_p) begin
          start      = 1'b1;
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (rise_p) begin
          capture = 1'b1;
        end else if (cnt == TIMEOUT_C) begin
          expire     = 1'b1;
          state_next = ARM;
        end
      end
      default: state_next = ARM;
    endcase
  end

  assign hs   = valid_q & res.meas_ready;
  assign load = capture & (~valid_q | res.meas_ready);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                 cnt <= '0;
    else if (start | capture)   cnt <= ONE;
    else if (expire)            cnt <= '0;
    else if (state == MEASURE)  cnt <= cnt + ONE;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (load) period_q <= cnt;

      if (load)    valid_q <= 1'b1;
      else if (hs) valid_q <= 1'b0;

      if (capture & valid_q & ~res.meas_ready) overrun_q <= 1'b1;
      else if (hs)                             overrun_q <= 1'b0;

      if (expire)     timeout_q <= 1'b1;
      else if (start) timeout_q <= 1'b0;
    end
  end

`ifdef DUTY_MEAS_EN
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] high_q;

  // A fall pulse always coincides with sig_d low, so gating on sig_d alone freezes hcnt at the fall
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hcnt   <= '0;
      high_q <= '0;
    end else begin
      if (start | capture)                hcnt <= ONE;
      else if (state == MEASURE && sig_d) hcnt <= hcnt + ONE;
      if (load) high_q <= hcnt;
    end
  end

  assign res.high_out = high_q;
`else
  assign res.high_out = '0;
`endif

  assign res.period_out = period_q;
  assign res.meas_valid = valid_q;
  assign res.overrun    = overrun_q;
  assign res.timeout    = timeout_q;
endmodule
